sort_reader: RTL and testbench
==============================

# sort_reader

Sequential read-out engine for the 16-entry sort buffer. On a start pulse it walks the buffer through its `pos`/`resultado` read interface, from entry 0 to DEPTH-1. Each entry goes to a downstream consumer over a valid/ready handshake. While streaming, it accumulates min, max and sum, and flags any ordering violation. It sits after the bubble-sort buffer and is the reader for the store/sort writer side.

## Interface
- `DATA_W`, default 5: width of one buffer entry.
- `DEPTH`, default 16: number of entries read per pass. Must be a power of two.
- `POS_W`, default 4: log2(DEPTH), the address width.
- `clockcito` input, 1 bit: the single clock. Everything is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: begins one pass. Sampled only in IDLE.
- `rd_pos` output, POS_W bits: address driven to the buffer read port.
- `rd_data` input, DATA_W bits: buffer contents at `rd_pos`, combinational from the buffer.
- `out_data` output, DATA_W bits: entry being offered downstream.
- `out_valid` output, 1 bit: `out_data` is valid.
- `out_ready` input, 1 bit: consumer accepts.
- `out_last` output, 1 bit: qualifies the final entry of the pass. Only meaningful with `out_valid`.
- `busy` output, 1 bit: a pass is in progress.
- `done` output, 1 bit: one-cycle pulse at the end of a pass.
- `order_err` output, 1 bit: sticky flag. Set if any accepted entry is smaller than the previously accepted entry.
- `min_val` output, DATA_W bits: running minimum of accepted entries.
- `max_val` output, DATA_W bits: running maximum of accepted entries.
- `sum_val` output, DATA_W+POS_W bits: running sum of accepted entries. Cannot overflow.

## Operation
- The FSM has four states: IDLE, ADDR, SEND, FIN.
- IDLE, with `start`=1: go to ADDR.
  - Index is set to 0 and `rd_pos` to 0.
  - `order_err` is cleared, `min_val` is set to all-ones, `max_val` to 0 and `sum_val` to 0.
- ADDR: `rd_pos` holds the index for exactly one cycle. At the next edge:
  - `rd_data` is captured into `out_data`.
  - `out_valid` is set to 1.
  - `out_last` is set to 1 if index = DEPTH-1.
  - The FSM goes to SEND.
- SEND: `out_data`, `out_valid` and `out_last` stay stable until an edge with `out_ready`=1 (transfer). On transfer:
  - `min_val`, `max_val` and `sum_val` are updated with `out_data`.
  - If index > 0 and `out_data` < the previously accepted value, `order_err` is set to 1.
  - `out_valid` and `out_last` are cleared.
  - If index = DEPTH-1, go to FIN. Otherwise index+1 is driven on `rd_pos` and the FSM goes to ADDR.
- FIN: `done`=1 for this one cycle, then IDLE.
- `busy`=1 in ADDR, SEND and FIN.
- `start` in any state other than IDLE is ignored, including during the FIN cycle.
- Statistics and `order_err` hold their values in IDLE until the next `start`.
- `out_data` holds its last value after the transfer; it is not cleared.
- Comparisons are unsigned. `sum_val` is a zero-extended add.
- System rule: the buffer must not be written or sorted while `busy`=1, because the block relies on `rd_data` being stable for the ADDR cycle.
- `reset` asserted at any time, including mid-pass, forces IDLE and all outputs to their reset values on the same cycle. Any partially streamed pass is abandoned, with no `done`.

## Timing
- Reset values:
  - `rd_pos`=0, `out_data`=0, `out_valid`=0, `out_last`=0.
  - `busy`=0, `done`=0, `order_err`=0.
  - `min_val`=0, `max_val`=0, `sum_val`=0.
- `start` sampled at edge 0: `busy`=1 and `rd_pos`=0 from edge 0. `out_valid` rises at edge 1.
- Each entry costs 1 ADDR cycle plus at least 1 SEND cycle.
- With `out_ready` held at 1:
  - Entry k transfers at edge 2k+2.
  - The last entry transfers at edge 2·DEPTH (32).
  - `done`=1 between edges 32 and 33.
  - `busy` falls at edge 33.
- Each cycle of `out_ready`=0 in SEND adds exactly one cycle to the pass.
- Statistics reflect an entry from the edge at which that entry transfers.
- Final statistics are valid when `done`=1.

## Test plan
- Buffer holds 0..15 ascending, `out_ready`=1, `start` pulse:
  - 16 transfers of 0..15, with `out_last` only on 15.
  - `done` between edges 32 and 33.
  - `min_val`=0, `max_val`=15, `sum_val`=120, `order_err`=0.
- Same buffer, `out_ready`=0 for 5 cycles while entry 3 is offered:
  - `out_data`=3 stays stable with `out_valid`=1.
  - `done` arrives 5 cycles later, between edges 37 and 38.
- Ascending buffer with entry 5 = 20, `out_ready`=1:
  - `order_err` rises at the transfer of entry 6 (value 6, edge 14) and stays 1.
  - `max_val`=20.
  - `sum_val` = 120 − 5 + 20 = 135.
- All entries 31:
  - `sum_val`=496, `min_val`=`max_val`=31, `order_err`=0.
  - Equal neighbours do not set `order_err`.
- Pulse `start` at edge 10 and again during the FIN cycle:
  - Both pulses are ignored; the pass completes normally.
  - The block returns to IDLE with a single `done` pulse.
- Assert `reset` during SEND of entry 7:
  - All outputs go to their reset values immediately, and no `done` is produced.
  - A new `start` then yields a full pass with fresh statistics.

Source files
------------

// File: rtl/sort_reader.sv
// Sequential read-out engine for the sort buffer: walks entries 0..DEPTH-1,
// streams them over valid/ready and keeps min/max/sum plus a sticky order flag.
module sort_reader #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 16,
    parameter int POS_W  = 4
) (
    input  logic                    clockcito,
    input  logic                    reset,
    input  logic                    start,
    output logic [POS_W-1:0]        rd_pos,
    input  logic [DATA_W-1:0]       rd_data,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    order_err,
    output logic [DATA_W-1:0]       min_val,
    output logic [DATA_W-1:0]       max_val,
    output logic [DATA_W+POS_W-1:0] sum_val
);

    typedef enum logic [1:0] {IDLE, ADDR, SEND, FIN} state_t;

    localparam logic [POS_W-1:0] LAST = POS_W'(DEPTH - 1);

    state_t                    state;
    logic [DATA_W-1:0]         prev_val;
    logic [DATA_W+POS_W-1:0]   sum_next;

    assign sum_next = sum_val + {{POS_W{1'b0}}, out_data};

    // rd_pos doubles as the entry index; the buffer must stay untouched while busy
    always_ff @(posedge clockcito or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_pos    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            order_err <= 1'b0;
            min_val   <= '0;
            max_val   <= '0;
            sum_val   <= '0;
            prev_val  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ADDR;
                        busy      <= 1'b1;
                        rd_pos    <= '0;
                        order_err <= 1'b0;
                        min_val   <= '1;
                        max_val   <= '0;
                        sum_val   <= '0;
                    end
                end
                ADDR: begin
                    out_data  <= rd_data;
                    out_valid <= 1'b1;
                    out_last  <= (rd_pos == LAST);
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_data < min_val) min_val <= out_data;
                        if (out_data > max_val) max_val <= out_data;
                        sum_val  <= sum_next;
                        prev_val <= out_data;
                        if (rd_pos != '0 && out_data < prev_val) order_err <= 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (rd_pos == LAST) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            rd_pos <= rd_pos + 1'b1;
                            state  <= ADDR;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_reader.sv
// Directed + randomized bench for sort_reader against an array-based model
// of the buffer contents and the stream/statistics it should produce.
module tb_sort_reader;

    localparam int DW = 5;
    localparam int DP = 16;
    localparam int PW = 4;

    logic          clockcito = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] rd_pos;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          order_err;
    logic [DW-1:0] min_val;
    logic [DW-1:0] max_val;
    logic [DW+PW-1:0] sum_val;

    logic [DW-1:0] mem [DP];

    int checks = 0;
    int failures = 0;

    assign rd_data = mem[rd_pos];

    always #5 clockcito = ~clockcito;

    sort_reader #(.DATA_W(DW), .DEPTH(DP), .POS_W(PW)) dut (
        .clockcito(clockcito), .reset(reset), .start(start),
        .rd_pos(rd_pos), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .order_err(order_err),
        .min_val(min_val), .max_val(max_val), .sum_val(sum_val)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Statistics over the first n accepted entries, straight from the buffer contents
    task automatic model(input int n, output int mn, output int mx, output int sm, output int oe);
        mn = (1 << DW) - 1; mx = 0; sm = 0; oe = 0;
        for (int j = 0; j < n; j++) begin
            if (int'(mem[j]) < mn) mn = int'(mem[j]);
            if (int'(mem[j]) > mx) mx = int'(mem[j]);
            sm += int'(mem[j]);
            if (j > 0 && mem[j] < mem[j-1]) oe = 1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_pos"}, int'(rd_pos), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_order_err"}, int'(order_err), 0);
        chk({tag, "_min"}, int'(min_val), 0);
        chk({tag, "_max"}, int'(max_val), 0);
        chk({tag, "_sum"}, int'(sum_val), 0);
    endtask

    // One pass, driven and sampled on negedges. Edge 0 is the start edge.
    task automatic run_pass(input string tag, input int stall_k, input int stall_n,
                            input bit rnd, input int sa, input int sb, input int abort_k,
                            output int done_edge, output int ndone, output int stalls);
        int k, stalled, e, mn, mx, sm, oe;
        bit rdy, xfer, fin;
        k = 0; stalled = 0; done_edge = -1; ndone = 0; stalls = 0; fin = 0;
        start = 1'b1;
        @(posedge clockcito); @(negedge clockcito);
        start = 1'b0;
        chk({tag, "_busy_e0"}, int'(busy), 1);
        chk({tag, "_rdpos_e0"}, int'(rd_pos), 0);
        chk({tag, "_valid_e0"}, int'(out_valid), 0);
        for (e = 1; e < 400 && !fin; e++) begin
            if (done) begin
                ndone++;
                if (done_edge < 0) done_edge = e - 1;
            end
            if (out_valid) begin
                chk($sformatf("%s_data%0d", tag, k), int'(out_data), int'(mem[k]));
                chk($sformatf("%s_last%0d", tag, k), int'(out_last), (k == DP-1) ? 1 : 0);
                if (k == abort_k) begin
                    reset = 1'b1;
                    #1;
                    chk_reset_vals({tag, "_abort"});
                    @(negedge clockcito);
                    chk({tag, "_abort_done"}, int'(done), 0);
                    reset = 1'b0;
                    start = 1'b0;
                    return;
                end
            end
            if (rnd) rdy = ($urandom_range(0, 3) != 0);
            else     rdy = !(out_valid && k == stall_k && stalled < stall_n);
            if (out_valid && !rdy) begin
                stalled++;
                stalls++;
            end
            xfer = out_valid && rdy;
            out_ready = rdy;
            start = (e == sa || e == sb);
            @(posedge clockcito); @(negedge clockcito);
            if (xfer) begin
                k++;
                model(k, mn, mx, sm, oe);
                chk($sformatf("%s_min%0d", tag, k), int'(min_val), mn);
                chk($sformatf("%s_max%0d", tag, k), int'(max_val), mx);
                chk($sformatf("%s_sum%0d", tag, k), int'(sum_val), sm);
                chk($sformatf("%s_oerr%0d", tag, k), int'(order_err), oe);
            end
            if (!busy) fin = 1;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_finished"}, int'(fin), 1);
        chk({tag, "_count"}, k, DP);
        chk({tag, "_done_after"}, int'(done), 0);
    endtask

    task automatic idle_hold(input string tag, input int cycles);
        int mn, mx, sm, oe;
        repeat (cycles) @(negedge clockcito);
        model(DP, mn, mx, sm, oe);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_idle_done"}, int'(done), 0);
        chk({tag, "_idle_min"}, int'(min_val), mn);
        chk({tag, "_idle_max"}, int'(max_val), mx);
        chk({tag, "_idle_sum"}, int'(sum_val), sm);
        chk({tag, "_idle_oerr"}, int'(order_err), oe);
    endtask

    initial begin
        int de, nd, st;
        for (int i = 0; i < DP; i++) mem[i] = DW'(i);

        repeat (3) @(negedge clockcito);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clockcito);

        // ascending, always ready
        run_pass("asc", -1, 0, 0, -1, -1, -1, de, nd, st);
        chk("asc_done_edge", de, 32);
        chk("asc_ndone", nd, 1);
        idle_hold("asc", 3);
        chk("asc_sum120", int'(sum_val), 120);

        // 5 stall cycles on entry 3
        run_pass("stall", 3, 5, 0, -1, -1, -1, de, nd, st);
        chk("stall_done_edge", de, 37);
        chk("stall_ndone", nd, 1);

        // entry 5 = 20 breaks ordering
        mem[5] = DW'(20);
        run_pass("bump", -1, 0, 0, -1, -1, -1, de, nd, st);
        chk("bump_done_edge", de, 32);
        idle_hold("bump", 2);
        chk("bump_sum135", int'(sum_val), 135);
        chk("bump_max20", int'(max_val), 20);
        chk("bump_oerr", int'(order_err), 1);

        // all entries at maximum
        for (int i = 0; i < DP; i++) mem[i] = '1;
        run_pass("ones", -1, 0, 0, -1, -1, -1, de, nd, st);
        idle_hold("ones", 2);
        chk("ones_sum496", int'(sum_val), 496);
        chk("ones_oerr", int'(order_err), 0);

        // start pulses at edge 10 and in the FIN cycle (edge 33) are ignored
        for (int i = 0; i < DP; i++) mem[i] = DW'(i);
        run_pass("sext", -1, 0, 0, 10, 33, -1, de, nd, st);
        chk("sext_done_edge", de, 32);
        chk("sext_ndone", nd, 1);
        idle_hold("sext", 4);

        // reset during SEND of entry 7, then a fresh pass
        run_pass("abort", -1, 0, 0, -1, -1, 7, de, nd, st);
        repeat (3) @(negedge clockcito);
        chk("abort_busy_after", int'(busy), 0);
        chk("abort_done_after", int'(done), 0);
        chk("abort_min_after", int'(min_val), 0);
        for (int i = 0; i < DP; i++) mem[i] = DW'(31 - 2 * i);
        run_pass("fresh", -1, 0, 0, -1, -1, -1, de, nd, st);
        chk("fresh_done_edge", de, 32);
        idle_hold("fresh", 2);

        // randomized contents and backpressure; half the passes are sorted
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < DP; i++) mem[i] = DW'($urandom_range(0, (1 << DW) - 1));
            if (p[0]) begin
                for (int i = 0; i < DP; i++)
                    for (int j = 0; j < DP - 1 - i; j++)
                        if (mem[j] > mem[j+1]) begin
                            logic [DW-1:0] t;
                            t = mem[j]; mem[j] = mem[j+1]; mem[j+1] = t;
                        end
            end
            run_pass($sformatf("rnd%0d", p), -1, 0, 1, -1, -1, -1, de, nd, st);
            chk($sformatf("rnd%0d_done_edge", p), de, 32 + st);
            chk($sformatf("rnd%0d_ndone", p), nd, 1);
            idle_hold($sformatf("rnd%0d", p), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
